fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS core. Holds the program counter, computes the next PC from the redirect request issued by the decode-stage controller (branch, j, jal, jr), presents the fetch address to instruction memory, and latches the fetched word with its PC+4/PC+8 into the D-stage registers. Decode control consumes `instr_D`; the hazard unit drives `stall`.

---
 rtl/fetch_stage.sv | 94 +++++++++
 tb/tb_fetch_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the five-stage MIPS core.
// Optional macro FETCH_FLUSH_EN adds i_flush, which loads a bubble into IF/ID.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_pc_sel,
  input  logic [2:0]  i_npc_sel,
  input  logic [31:0] i_rs_fwd_d,
`ifdef FETCH_FLUSH_EN
  input  logic        i_flush,
`endif
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_pc_f,
  output logic [31:0] o_instr_d,
  output logic [31:0] o_pc_d,
  output logic [31:0] o_pc4_d,
  output logic [31:0] o_pc8_d,
  output logic [31:0] o_npc_target
);

  localparam logic [2:0] NPC_BEQ = 3'b001;
  localparam logic [2:0] NPC_JAL = 3'b010;
  localparam logic [2:0] NPC_JR  = 3'b011;
  localparam logic [2:0] NPC_J   = 3'b100;

  logic [31:0] r_pc_f;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc4_d;
  logic [31:0] r_pc8_d;

  logic [31:0] w_pc4_f;
  logic [31:0] w_pc8_f;
  logic [31:0] w_br_off;
  logic [31:0] w_target;
  logic [31:0] w_pc_next;
  logic [31:0] w_instr_next;

  assign w_pc4_f  = r_pc_f + 32'd4;
  assign w_pc8_f  = r_pc_f + 32'd8;
  assign w_br_off = {{14{r_instr_d[15]}}, r_instr_d[15:0], 2'b00};

  // Target uses only D-stage state, so the delay-slot fetch never affects it.
  always_comb begin
    w_target = w_pc4_f;
    case (i_npc_sel)
      NPC_BEQ:        w_target = r_pc4_d + w_br_off;
      NPC_JAL, NPC_J: w_target = {r_pc4_d[31:28], r_instr_d[25:0], 2'b00};
      NPC_JR:         w_target = i_rs_fwd_d & 32'hFFFF_FFFC;
      default:        w_target = w_pc4_f;
    endcase
  end

  always_comb begin
    w_pc_next = w_pc4_f;
    if (i_stall)       w_pc_next = r_pc_f;
    else if (i_pc_sel) w_pc_next = w_target;
  end

`ifdef FETCH_FLUSH_EN
  assign w_instr_next = i_flush ? 32'd0 : i_imem_rdata;
`else
  assign w_instr_next = i_imem_rdata;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc_f    <= PC_RESET;
      r_instr_d <= 32'd0;
      r_pc_d    <= PC_RESET;
      r_pc4_d   <= PC_RESET + 32'd4;
      r_pc8_d   <= PC_RESET + 32'd8;
    end else if (!i_stall) begin
      r_pc_f    <= w_pc_next;
      r_instr_d <= w_instr_next;
      r_pc_d    <= r_pc_f;
      r_pc4_d   <= w_pc4_f;
      r_pc8_d   <= w_pc8_f;
    end
  end

  assign o_imem_addr  = r_pc_f;
  assign o_pc_f       = r_pc_f;
  assign o_instr_d    = r_instr_d;
  assign o_pc_d       = r_pc_d;
  assign o_pc4_d      = r_pc4_d;
  assign o_pc8_d      = r_pc8_d;
  assign o_npc_target = w_target;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scoreboard bench for fetch_stage: expectations are queued with each
// stimulus step and popped against the DUT outputs at the sampling point.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        pc_sel;
  logic [2:0]  npc_sel;
  logic [31:0] rs_fwd;
  logic        flush;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc_f, instr_d, pc_d, pc4_d, pc8_d, npc_target;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef enum int {S_PC_F, S_INSTR, S_PC_D, S_PC4, S_PC8, S_TGT, S_ADDR} sel_t;
  typedef struct {
    string       tag;
    sel_t        sel;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  fetch_stage #(.PC_RESET(32'h0000_3000)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_stall      (stall),
    .i_pc_sel     (pc_sel),
    .i_npc_sel    (npc_sel),
    .i_rs_fwd_d   (rs_fwd),
`ifdef FETCH_FLUSH_EN
    .i_flush      (flush),
`endif
    .o_imem_addr  (imem_addr),
    .i_imem_rdata (imem_rdata),
    .o_pc_f       (pc_f),
    .o_instr_d    (instr_d),
    .o_pc_d       (pc_d),
    .o_pc4_d      (pc4_d),
    .o_pc8_d      (pc8_d),
    .o_npc_target (npc_target)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h0000_3000)      return 32'h1000_0003;
    else if (a == 32'h0000_3004) return 32'h0C00_0C10;
    else                         return {16'hDEAD, a[15:0]};
  endfunction

  always_comb imem_rdata = imem(imem_addr);

  function automatic logic [31:0] observe(input sel_t s);
    case (s)
      S_PC_F:  return pc_f;
      S_INSTR: return instr_d;
      S_PC_D:  return pc_d;
      S_PC4:   return pc4_d;
      S_PC8:   return pc8_d;
      S_TGT:   return npc_target;
      default: return imem_addr;
    endcase
  endfunction

  task automatic expect_v(input string tag, input sel_t s, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.sel = s; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = observe(e.sel);
      n_cmp++;
      assert (o === e.val)
      else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; pc_sel = 1'b0; npc_sel = 3'b000;
    rs_fwd = 32'd0; flush = 1'b0;
    @(negedge clk);
    expect_v("rst_pc_f",  S_PC_F,  32'h3000);
    expect_v("rst_addr",  S_ADDR,  32'h3000);
    expect_v("rst_instr", S_INSTR, 32'h0);
    expect_v("rst_pc_d",  S_PC_D,  32'h3000);
    expect_v("rst_pc4",   S_PC4,   32'h3004);
    expect_v("rst_pc8",   S_PC8,   32'h3008);
    expect_v("rst_tgt",   S_TGT,   32'h3004);
    drain();

    reset = 1'b0;
    cyc();
    expect_v("first_pc_f",  S_PC_F,  32'h3004);
    expect_v("first_instr", S_INSTR, 32'h1000_0003);
    expect_v("first_pc_d",  S_PC_D,  32'h3000);
    expect_v("first_pc4",   S_PC4,   32'h3004);
    expect_v("first_pc8",   S_PC8,   32'h3008);
    expect_v("seq_tgt",     S_TGT,   32'h3008);
    drain();

    // beq +3 in D
    npc_sel = 3'b001; pc_sel = 1'b1; #1;
    expect_v("beq_tgt", S_TGT, 32'h3010);
    drain();
    cyc();
    expect_v("beq_pc_f",   S_PC_F,  32'h3010);
    expect_v("delay_inst", S_INSTR, 32'h0C00_0C10);
    expect_v("delay_pc_d", S_PC_D,  32'h3004);
    expect_v("delay_pc4",  S_PC4,   32'h3008);
    expect_v("delay_pc8",  S_PC8,   32'h300C);
    drain();

    npc_sel = 3'b010; #1;
    expect_v("jal_tgt", S_TGT, 32'h3040);
    drain();
    npc_sel = 3'b100; #1;
    expect_v("j_tgt", S_TGT, 32'h3040);
    drain();
    npc_sel = 3'b101; #1;
    expect_v("undef_tgt", S_TGT, 32'h3014);
    drain();
    npc_sel = 3'b010; #1;
    cyc();
    expect_v("jal_pc_f",  S_PC_F,  32'h3040);
    expect_v("jal_instr", S_INSTR, 32'hDEAD_3010);
    expect_v("jal_pc_d",  S_PC_D,  32'h3010);
    drain();

    rs_fwd = 32'h0000_3027; npc_sel = 3'b011; #1;
    expect_v("jr_tgt", S_TGT, 32'h3024);
    drain();
    cyc();
    expect_v("jr_pc_f",  S_PC_F,  32'h3024);
    expect_v("jr_instr", S_INSTR, 32'hDEAD_3040);
    drain();

    // stall wins over a pending redirect
    rs_fwd = 32'h0000_5000; stall = 1'b1;
    cyc();
    expect_v("stall1_pc_f",  S_PC_F,  32'h3024);
    expect_v("stall1_instr", S_INSTR, 32'hDEAD_3040);
    drain();
    cyc();
    expect_v("stall2_pc_f",  S_PC_F,  32'h3024);
    expect_v("stall2_instr", S_INSTR, 32'hDEAD_3040);
    expect_v("stall2_pc_d",  S_PC_D,  32'h3040);
    drain();
    stall = 1'b0;
    cyc();
    expect_v("unstall_pc_f",  S_PC_F,  32'h5000);
    expect_v("unstall_instr", S_INSTR, 32'hDEAD_3024);
    drain();
    pc_sel = 1'b0;
    cyc();
    expect_v("once_pc_f",  S_PC_F,  32'h5004);
    expect_v("once_instr", S_INSTR, 32'hDEAD_5000);
    drain();

    // PC wrap and negative beq offset
    rs_fwd = 32'hFFFF_FFFF; npc_sel = 3'b011; pc_sel = 1'b1; #1;
    expect_v("jr_lowbits", S_TGT, 32'hFFFF_FFFC);
    drain();
    cyc();
    expect_v("top_pc_f", S_PC_F, 32'hFFFF_FFFC);
    drain();
    pc_sel = 1'b0; npc_sel = 3'b000;
    cyc();
    expect_v("wrap_pc_f",  S_PC_F,  32'h0);
    expect_v("wrap_pc_d",  S_PC_D,  32'hFFFF_FFFC);
    expect_v("wrap_pc4",   S_PC4,   32'h0);
    expect_v("wrap_pc8",   S_PC8,   32'h4);
    expect_v("wrap_instr", S_INSTR, 32'hDEAD_FFFC);
    drain();
    npc_sel = 3'b001; #1;
    expect_v("beq_neg_tgt", S_TGT, 32'hFFFF_FFF0);
    drain();
    npc_sel = 3'b000;

`ifdef FETCH_FLUSH_EN
    flush = 1'b1;
    cyc();
    expect_v("flush_pc_f",  S_PC_F,  32'h4);
    expect_v("flush_instr", S_INSTR, 32'h0);
    expect_v("flush_pc_d",  S_PC_D,  32'h0);
    expect_v("flush_pc8",   S_PC8,   32'h8);
    drain();
    stall = 1'b1;
    cyc();
    expect_v("flstall_pc_f",  S_PC_F,  32'h4);
    expect_v("flstall_instr", S_INSTR, 32'h0);
    expect_v("flstall_pc_d",  S_PC_D,  32'h0);
    drain();
    stall = 1'b0; flush = 1'b0;
    cyc();
    expect_v("postfl_pc_f",  S_PC_F,  32'h8);
    expect_v("postfl_instr", S_INSTR, 32'hDEAD_0004);
    drain();
`endif

    // async reset mid-cycle during stall + redirect
    stall = 1'b1; pc_sel = 1'b1; npc_sel = 3'b011; rs_fwd = 32'h0000_5000;
    @(posedge clk); #2;
    reset = 1'b1; #1;
    expect_v("mid_rst_pc_f",  S_PC_F,  32'h3000);
    expect_v("mid_rst_instr", S_INSTR, 32'h0);
    expect_v("mid_rst_pc_d",  S_PC_D,  32'h3000);
    expect_v("mid_rst_pc4",   S_PC4,   32'h3004);
    expect_v("mid_rst_pc8",   S_PC8,   32'h3008);
    drain();
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; pc_sel = 1'b0; npc_sel = 3'b000;
    cyc();
    expect_v("rel_pc_f",  S_PC_F,  32'h3004);
    expect_v("rel_instr", S_INSTR, 32'h1000_0003);
    drain();
    cyc();
    expect_v("rel2_pc_f", S_PC_F, 32'h3008);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
